// File: rtl/button_pkg.sv
// Shared definitions for the button event arbiter: arbiter state encoding,
// debounce defaults for board and simulation, and the event-id width.
package button_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  localparam int DEBOUNCE_BOARD = 250000;
  localparam int DEBOUNCE_SIM   = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse when the debounced level rises.
module debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             lvl_q, lvl_d;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q != lvl_q) begin
      if (cnt_q == CNT_LAST) lvl_d = ~lvl_q;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values (meta_q -> sync_q stays a real 2-stage chain).
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N push buttons, latches each clean press as a pending bit and
// offers the pending events one at a time through a round-robin valid/ready port.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int N               = 4,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_BOARD,
  localparam int ID_W            = id_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    btn_raw,
  output logic [N-1:0]    btn_level,
  output logic [N-1:0]    pending,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready
);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    rise, pending_q, pending_d, clr_mask;
  logic [ID_W-1:0] evt_id_q, evt_id_d, ptr_q, ptr_d;
  logic            load_id, accept;

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_raw_i(btn_raw[g]),
      .level_o  (btn_level[g]),
      .rise_o   (rise[g])
    );
  end

  // First set bit at or above start, wrapping past N-1 back to 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req, input logic [ID_W-1:0] start);
    logic [N-1:0]  rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0] sum;
    rot = N'({req, req} >> start);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[ID_W'(k)]) off = ID_W'(k);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
    return sum[ID_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pending_q) state_d = ST_OFFER;
      ST_OFFER: if (evt_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = 1'b0;
    load_id   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE:  load_id = |pending_q;
      ST_OFFER: begin
        evt_valid = 1'b1;
        accept    = evt_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    clr_mask  = accept ? (N'(1) << evt_id_q) : '0;
    // A press landing on the accept edge is a new event, so set beats clear.
    pending_d = (pending_q & ~clr_mask) | rise;
    evt_id_d  = load_id ? rr_pick(pending_q, ptr_q) : evt_id_q;
    ptr_d     = ptr_q;
    if (accept) ptr_d = (evt_id_q == ID_W'(N - 1)) ? '0 : evt_id_q + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      evt_id_q  <= '0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      evt_id_q  <= evt_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign pending = pending_q;
  assign evt_id  = evt_id_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed scenarios plus randomized button/ready/reset traffic, every cycle
// compared against an event-level reference model of the arbiter.
module tb_button_event_arbiter;
  import button_pkg::*;

  localparam int N    = 4;
  localparam int D    = DEBOUNCE_SIM;
  localparam int ID_W = id_width(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    btn_raw;
  logic [N-1:0]    btn_level;
  logic [N-1:0]    pending;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N              (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .pending  (pending),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw pins seen at the last two edges, per-channel run of
  // disagreeing samples, debounced level, pending set, current offer, pointer.
  logic [N-1:0] seen0, seen1, m_lvl, m_pend, m_rose;
  int           m_run [N];
  logic         m_offer;
  int           m_id, m_ptr;
  int           ev_q[$];

  task automatic model_step();
    logic [N-1:0] pend_n, rose_n;
    logic         s;
    if (rst) begin
      seen0 = '0; seen1 = '0; m_lvl = '0; m_pend = '0; m_rose = '0;
      m_offer = 1'b0; m_id = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_run[ID_W'(i)] = 0;
      return;
    end
    pend_n = m_pend;
    if (m_offer) begin
      if (evt_ready) begin
        pend_n  = pend_n & ~(N'(1) << m_id);
        m_ptr   = (m_id + 1) % N;
        m_offer = 1'b0;
      end
    end else if (m_pend != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (m_pend[ID_W'((m_ptr + k) % N)]) m_id = (m_ptr + k) % N;
      m_offer = 1'b1;
    end
    m_pend = pend_n | m_rose;
    rose_n = '0;
    for (int i = 0; i < N; i++) begin
      s = seen1[ID_W'(i)];
      if (s == m_lvl[ID_W'(i)]) m_run[ID_W'(i)] = 0;
      else if (m_run[ID_W'(i)] == D - 1) begin
        m_lvl[ID_W'(i)]  = s;
        m_run[ID_W'(i)]  = 0;
        rose_n[ID_W'(i)] = s;
      end else m_run[ID_W'(i)]++;
    end
    m_rose = rose_n;
    seen1  = seen0;
    seen0  = btn_raw;
  endtask

  // One clock: log any handshake, advance the model, compare at the falling edge.
  task automatic tick();
    if (evt_valid && evt_ready && !rst) ev_q.push_back(int'(evt_id));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("btn_level", 32'(btn_level), 32'(m_lvl));
    check("pending",   32'(pending),   32'(m_pend));
    check("evt_valid", 32'(evt_valid), 32'(m_offer));
    check("evt_id",    32'(evt_id),    32'(m_id));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic int ev_at(input int i);
    return (i < ev_q.size()) ? ev_q[i] : -1;
  endfunction

  int first, first_id;

  initial begin
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
    @(negedge clk);
    run(3);
    check("reset_level",   32'(btn_level), 0);
    check("reset_pending", 32'(pending),   0);
    check("reset_valid",   32'(evt_valid), 0);
    check("reset_id",      32'(evt_id),    0);
    rst = 1'b0;

    // Single press on ch2, consumer always ready.
    ev_q.delete(); evt_ready = 1'b1; btn_raw = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("single_valid", 32'(evt_valid), 32'(k == 7));
      if (k == 7) check("single_id", 32'(evt_id), 2);
    end
    check("single_pending_clear", 32'(pending), 0);
    btn_raw = '0; run(10);
    check("single_count", ev_q.size(), 1);
    check("single_ev0", ev_at(0), 2);

    // Bounce on ch0: three highs then a low, five times, then steady high.
    ev_q.delete();
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < 4; p++) begin
        btn_raw[0] = (p != 3);
        tick();
        check("bounce_level", 32'(btn_level[0]), 0);
        check("bounce_pending", 32'(pending), 0);
      end
    btn_raw[0] = 1'b1; first = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (first < 0 && btn_level[0]) first = k;
    end
    check("bounce_rise_edge", first, 5);
    btn_raw = '0; run(10);
    check("bounce_count", ev_q.size(), 1);
    check("bounce_ev0", ev_at(0), 0);

    // Round-robin from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    ev_q.delete();
    btn_raw = 4'b0011; run(14); btn_raw = '0; run(10);
    btn_raw = 4'b1001; run(14); btn_raw = '0; run(10);
    check("rr_count", ev_q.size(), 4);
    check("rr_ev0", ev_at(0), 0);
    check("rr_ev1", ev_at(1), 1);
    check("rr_ev2", ev_at(2), 3);
    check("rr_ev3", ev_at(3), 0);

    // Backpressure: offer of ch1 holds while ch2 queues behind it.
    ev_q.delete(); evt_ready = 1'b0;
    btn_raw = 4'b0010; run(10);
    btn_raw = 4'b0110; run(10);
    check("bp_valid_held", 32'(evt_valid), 1);
    check("bp_id_held", 32'(evt_id), 1);
    check("bp_pending", 32'(pending), 32'(4'b0110));
    evt_ready = 1'b1;
    tick(); check("bp_idle_gap", 32'(evt_valid), 0);
    tick(); check("bp_second_valid", 32'(evt_valid), 1);
    check("bp_second_id", 32'(evt_id), 2);
    tick(); check("bp_after_second", 32'(evt_valid), 0);
    btn_raw = '0; run(10);
    check("bp_count", ev_q.size(), 2);
    check("bp_ev0", ev_at(0), 1);
    check("bp_ev1", ev_at(1), 2);

    // Coalescing: press, release, press ch1 while the first offer is stalled.
    ev_q.delete(); evt_ready = 1'b0;
    btn_raw = 4'b0010; run(8); btn_raw = '0; run(8);
    btn_raw = 4'b0010; run(8); btn_raw = '0; run(8);
    check("coal_pending", 32'(pending), 32'(4'b0010));
    evt_ready = 1'b1; run(4);
    check("coal_count", ev_q.size(), 1);
    check("coal_ev0", ev_at(0), 1);

    // Same-edge set and clear on ch3.
    ev_q.delete(); evt_ready = 1'b0;
    btn_raw = 4'b1000; run(9);
    btn_raw = '0; run(8);
    btn_raw = 4'b1000; run(6);
    evt_ready = 1'b1; tick();
    check("same_pending_kept", 32'(pending), 32'(4'b1000));
    check("same_idle", 32'(evt_valid), 0);
    tick();
    check("same_second_valid", 32'(evt_valid), 1);
    check("same_second_id", 32'(evt_id), 3);
    btn_raw = '0; run(10);
    check("same_count", ev_q.size(), 2);
    check("same_ev0", ev_at(0), 3);
    check("same_ev1", ev_at(1), 3);

    // Reset while ch2 is being offered and still held.
    ev_q.delete(); evt_ready = 1'b0;
    btn_raw = 4'b0100; run(9);
    check("rst_pre_valid", 32'(evt_valid), 1);
    check("rst_pre_id", 32'(evt_id), 2);
    rst = 1'b1; tick();
    check("rst_level", 32'(btn_level), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    rst = 1'b0; first = -1; first_id = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (first < 0 && evt_valid) begin
        first    = k;
        first_id = int'(evt_id);
      end
    end
    check("rst_return_edge", first, D + 3);
    check("rst_return_id", first_id, 2);
    btn_raw = '0; evt_ready = 1'b1; run(12);

    // Randomized traffic against the model.
    ev_q.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) btn_raw[ID_W'(i)] = ~btn_raw[ID_W'(i)];
      evt_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Conditions N asynchronous push-button inputs and turns each clean press into one event, granted one at a time. Each button is synchronised, debounced, and rising-edge detected. The resulting events are queued as one pending bit per button and offered through a round-robin valid/ready port. The block sits between the board pins and the project's control FSM, so downstream logic never sees metastable, bouncing or duplicated button presses.

## Interface
- N, 4: number of button channels (2..16).
- DEBOUNCE_CYCLES, 250000: consecutive stable `clk` cycles required before a level change is accepted (≥2). Set to 4 in simulation.
- clk  in  1  system clock. All flops update on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- btn_raw  in  N  asynchronous button pins, active-high.
- btn_level  out  N  debounced button levels. Reset value 0.
- pending  out  N  one bit per channel: press seen but not yet accepted. Reset value 0.
- evt_valid  out  1  an event is offered. Reset value 0.
- evt_id  out  ID_W = clog2(N)  channel index of the offered event. Reset value 0.
- evt_ready  in  1  consumer accepts the event when `evt_valid` and `evt_ready` are both high on a clock edge.

## Operation
- **Per channel:** a 2-flop synchroniser produces `s`. A debounce counter runs alongside a stable level `lvl`.
  - If `s == lvl`, the counter clears to 0.
  - If `s != lvl` and the counter equals DEBOUNCE_CYCLES-1, `lvl` toggles and the counter clears.
  - Otherwise the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- **Pending:** a 0→1 transition of `lvl` sets `pending[i]`.
  - A release (`lvl` 1→0) does nothing.
  - A second press while `pending[i]` is already 1 is coalesced into the existing bit.
- **Arbiter FSM with round-robin pointer `ptr`** (reset value 0):
  - IDLE: if `pending` is nonzero, select the first set bit scanning from `ptr` upward with wrap-around. Register it into `evt_id` and go to OFFER. `evt_valid` is 0 in IDLE.
  - OFFER: `evt_valid` is 1 and `evt_id` is held stable. On `evt_ready`: clear `pending[evt_id]`, set `ptr = (evt_id+1) mod N`, return to IDLE. Without `evt_ready`, stay in OFFER with no change.
- **Set and clear on the same channel in the same cycle:** set wins, and `pending` stays 1 because it is a new press.
- New pending bits never change an offer already in progress.
- **Reset mid-operation:**
  - Synchroniser flops, counters, `lvl`, `pending`, `ptr` and the FSM all clear. An in-flight event is dropped.
  - A button held through reset is reported as a new press, with full latency from reset release.

## Timing
- `btn_raw` goes high and stays high from edge E0:
  - `s` is high after E1.
  - `btn_level` is high after E(D+1), where D = DEBOUNCE_CYCLES.
  - `pending` is high after E(D+2).
  - `evt_valid` is high after E(D+3), provided the FSM is IDLE.
- Release latency to `btn_level`=0 is the same D+1 cycles.
- Throughput: at most one event every 2 cycles, because IDLE always lasts at least one cycle between offers.
- `evt_ready` is sampled only in OFFER. `evt_valid` never depends combinationally on `evt_ready`.

## Structure
- Shared package `button_pkg`:
  - arbiter state encoding (IDLE=0, OFFER=1);
  - default DEBOUNCE_CYCLES for board and for simulation;
  - ID_W derivation.
- Sub-module `debounce_chan` contains one synchroniser, counter and level flop, plus its rising-edge pulse output. It is instantiated N times in a generate loop.
- The top level holds the pending register, the round-robin select and the FSM.

## Test plan
All scenarios use N=4 and D=4.
- **Single press:** raise ch2 from E0 and hold for 12 cycles, `evt_ready`=1 → `evt_valid` rises after E7 with `evt_id`=2. It is accepted at the next edge, `pending` returns to 0, and exactly one event is produced.
- **Bounce:** ch0 pattern 1,1,1,0 repeated 5 times, then steady 1 → no `btn_level`/`pending` activity during the bounce. Exactly one event, with `btn_level[0]` rising 5 cycles after steady 1 begins.
- **Round-robin:** `ptr`=0, press ch0 and ch1 together → events 0 then 1, leaving `ptr`=2. Then press ch0 and ch3 together → events 3 then 0.
- **Backpressure:** `evt_ready`=0, press ch1, then press ch2 → `evt_id` holds 1 with `evt_valid` high and `pending`=0110. Raise `evt_ready` → events 1 then 2, with one idle cycle between them.
- **Coalescing and same-cycle set/clear:** `evt_ready`=0, press/release/press ch1 → one event. Arrange a ch3 rising `lvl` on the same edge that ch3 is accepted → `pending[3]` stays 1 and a second event 3 follows.
- **Reset mid-offer:** `evt_valid`=1 for ch2 and ch2 still held, pulse `rst` for 1 cycle → all outputs 0 after that edge. `evt_valid` returns D+3 cycles after reset release with `evt_id`=2.
